// File: rtl/mips_pkg.sv
// Encodings shared by the fetch unit and the multicycle controller:
// next-PC selects, fetch FSM states and the default reset PC.
package mips_pkg;

   typedef enum logic [1:0] {
      NPC_PLUS4 = 2'b00,
      NPC_J     = 2'b01,
      NPC_BEQ   = 2'b10,
      NPC_JR    = 2'b11
   } npc_sel_e;

   typedef enum logic [1:0] {
      F_IDLE = 2'b00,
      F_REQ  = 2'b01,
      F_DONE = 2'b10
   } fstate_e;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC mux: sequential, j/jal, beq and jr targets.
// All additions wrap modulo 2^32.
module npc_calc
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic        zero_i,
   input  logic [31:0] jr_addr_i,
   input  logic [1:0]  npc_sel_i,
   output logic [31:0] npc_o,
   output logic [31:0] pc_plus4_o
);

   logic signed [31:0] br_off;

   assign pc_plus4_o = pc_i + 32'd4;
   // Word offset: sign-extend imm16 and scale to bytes.
   assign br_off     = {{14{ir_i[15]}}, ir_i[15:0], 2'b00};

   always_comb begin
      npc_o = pc_plus4_o;
      case (npc_sel_i)
         NPC_PLUS4: npc_o = pc_plus4_o;
         NPC_J:     npc_o = {pc_i[31:28], ir_i[25:0], 2'b00};
         NPC_BEQ:   npc_o = zero_i ? (pc_plus4_o + br_off) : pc_plus4_o;
         NPC_JR:    npc_o = jr_addr_i;
         default:   npc_o = pc_plus4_o;
      endcase
   end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC/IR registers, req/ack fetch FSM with timeout.
// Define IFU_ALIGN_CHK_EN to refuse fetches from a non-word-aligned PC.
module ifu_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_go,
   input  logic        pc_wr,
   input  logic        ir_wr,
   input  logic [1:0]  npc_sel,
   input  logic        zero,
   input  logic [31:0] jr_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        ir_valid,
   output logic        fetch_busy,
   output logic        fetch_err
);

   localparam int             CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   fstate_e          state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      pc_q, pc_d, ir_q, npc;
   logic             err_q;
   logic             go_ok;

   npc_calc u_npc (
      .pc_i       (pc_q),
      .ir_i       (ir_q),
      .zero_i     (zero),
      .jr_addr_i  (jr_addr),
      .npc_sel_i  (npc_sel),
      .npc_o      (npc),
      .pc_plus4_o (pc_plus4)
   );

   // PC is frozen while a request is outstanding so imem_addr stays stable.
   assign pc_d = (pc_wr && (state_q != F_REQ)) ? npc : pc_q;

`ifdef IFU_ALIGN_CHK_EN
   assign go_ok = (pc_d[1:0] == 2'b00);
`else
   assign go_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= F_IDLE;
         cnt_q   <= '0;
         pc_q    <= PC_RESET;
         ir_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q <= pc_d;
         case (state_q)
            F_IDLE: begin
               if (fetch_go) begin
                  if (go_ok) begin
                     state_q <= F_REQ;
                     cnt_q   <= '0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            F_REQ: begin
               // An ack on the final allowed cycle still wins over the timeout.
               if (imem_ack) begin
                  if (ir_wr) ir_q <= imem_rdata;
                  state_q <= F_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= F_IDLE;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            F_DONE:  state_q <= F_IDLE;
            default: state_q <= F_IDLE;
         endcase
      end
   end

   assign imem_req    = (state_q == F_REQ);
   assign fetch_busy  = (state_q == F_REQ);
   assign ir_valid    = (state_q == F_DONE);
   assign imem_addr   = pc_q;
   assign instruction = ir_q;
   assign pc          = pc_q;
   assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch; adapts its alignment expectations to IFU_ALIGN_CHK_EN.
module tb_ifu_fetch;

   logic        clk, rst, fetch_go, pc_wr, ir_wr, zero, imem_ack;
   logic [1:0]  npc_sel;
   logic [31:0] jr_addr, imem_rdata;
   logic        imem_req, ir_valid, fetch_busy, fetch_err;
   logic [31:0] imem_addr, instruction, pc, pc_plus4;

   int vectors = 0;
   int errors  = 0;

   ifu_fetch dut (
      .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_wr(pc_wr), .ir_wr(ir_wr),
      .npc_sel(npc_sel), .zero(zero), .jr_addr(jr_addr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4),
      .ir_valid(ir_valid), .fetch_busy(fetch_busy), .fetch_err(fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // Pulses fetch_go, acks on the ack_at-th request cycle (0 = never), observes ncyc cycles.
   task automatic run_fetch(input logic [31:0] word, input int ack_at, input logic wr, input int ncyc,
                            output int busy, output int vld, output logic [31:0] addr);
      @(negedge clk);
      fetch_go = 1'b1; ir_wr = wr;
      busy = 0; vld = 0; addr = 32'hxxxx_xxxx;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         fetch_go = 1'b0; imem_ack = 1'b0;
         if (fetch_busy) begin
            busy++;
            addr = imem_addr;
            if (busy == ack_at) begin imem_ack = 1'b1; imem_rdata = word; end
         end
         if (ir_valid) vld++;
      end
      imem_ack = 1'b0;
   endtask

   task automatic write_pc(input logic [1:0] sel, input logic z, input logic [31:0] jra);
      @(negedge clk);
      pc_wr = 1'b1; npc_sel = sel; zero = z; jr_addr = jra;
      @(negedge clk);
      pc_wr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
      vectors++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h expected %h", instruction, 32'h0); end
      vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
      vectors++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", ir_valid); end
      vectors++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
      vectors++; if (pc_plus4 !== 32'h0000_3004) begin errors++; $display("FAIL reset_pc4: got %h expected %h", pc_plus4, 32'h3004); end
   endtask

   task automatic test_fetch();
      int b, v; logic [31:0] a;
      run_fetch(32'h3408_0005, 3, 1'b1, 6, b, v, a);
      vectors++; if (a !== 32'h0000_3000) begin errors++; $display("FAIL fetch_addr: got %h expected %h", a, 32'h3000); end
      vectors++; if (b !== 3) begin errors++; $display("FAIL fetch_busy: got %0d expected 3", b); end
      vectors++; if (v !== 1) begin errors++; $display("FAIL fetch_vld: got %0d expected 1", v); end
      vectors++; if (instruction !== 32'h3408_0005) begin errors++; $display("FAIL fetch_ir: got %h expected %h", instruction, 32'h34080005); end
      vectors++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL fetch_pc: got %h expected %h", pc, 32'h3000); end
   endtask

   task automatic test_beq();
      int b, v; logic [31:0] a;
      run_fetch(32'h1000_FFFF, 1, 1'b1, 4, b, v, a);
      write_pc(2'b10, 1'b1, 32'h0);
      vectors++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL beq_taken: got %h expected %h", pc, 32'h3000); end
      write_pc(2'b10, 1'b0, 32'h0);
      vectors++; if (pc !== 32'h0000_3004) begin errors++; $display("FAIL beq_not_taken: got %h expected %h", pc, 32'h3004); end
      vectors++; if (pc_plus4 !== 32'h0000_3008) begin errors++; $display("FAIL beq_pc4: got %h expected %h", pc_plus4, 32'h3008); end
   endtask

   task automatic test_jump();
      int b, v; logic [31:0] a;
      run_fetch(32'h0800_0C10, 2, 1'b1, 5, b, v, a);
      vectors++; if (a !== 32'h0000_3004) begin errors++; $display("FAIL jump_fetch_addr: got %h expected %h", a, 32'h3004); end
      write_pc(2'b01, 1'b0, 32'h0);
      vectors++; if (pc !== 32'h0000_3040) begin errors++; $display("FAIL jump_j: got %h expected %h", pc, 32'h3040); end
      write_pc(2'b11, 1'b0, 32'h0000_3100);
      vectors++; if (pc !== 32'h0000_3100) begin errors++; $display("FAIL jump_jr: got %h expected %h", pc, 32'h3100); end
   endtask

   task automatic test_ir_wr_off();
      int b, v; logic [31:0] a;
      run_fetch(32'hDEAD_BEEF, 1, 1'b0, 4, b, v, a);
      vectors++; if (instruction !== 32'h0800_0C10) begin errors++; $display("FAIL irwr_off_ir: got %h expected %h", instruction, 32'h08000C10); end
      vectors++; if (v !== 1) begin errors++; $display("FAIL irwr_off_vld: got %0d expected 1", v); end
   endtask

   task automatic test_ack_outside();
      @(negedge clk);
      ir_wr = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem_ack = 1'b0;
      vectors++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_vld: got %b expected 0", ir_valid); end
      vectors++; if (instruction !== 32'h0800_0C10) begin errors++; $display("FAIL stray_ack_ir: got %h expected %h", instruction, 32'h08000C10); end
   endtask

   task automatic test_go_with_pcwr();
      @(negedge clk);
      fetch_go = 1'b1; pc_wr = 1'b1; npc_sel = 2'b00; ir_wr = 1'b1;
      @(negedge clk);
      fetch_go = 1'b0; pc_wr = 1'b0;
      vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL gopc_req: got %b expected 1", imem_req); end
      vectors++; if (imem_addr !== 32'h0000_3104) begin errors++; $display("FAIL gopc_addr: got %h expected %h", imem_addr, 32'h3104); end
      imem_ack = 1'b1; imem_rdata = 32'h2402_000A;
      @(negedge clk);
      imem_ack = 1'b0;
      vectors++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL gopc_vld: got %b expected 1", ir_valid); end
      vectors++; if (instruction !== 32'h2402_000A) begin errors++; $display("FAIL gopc_ir: got %h expected %h", instruction, 32'h2402000A); end
      @(negedge clk);
   endtask

   task automatic test_ack_last_cycle();
      int b, v; logic [31:0] a;
      run_fetch(32'h0000_0020, 16, 1'b1, 20, b, v, a);
      vectors++; if (b !== 16) begin errors++; $display("FAIL last_ack_busy: got %0d expected 16", b); end
      vectors++; if (v !== 1) begin errors++; $display("FAIL last_ack_vld: got %0d expected 1", v); end
      vectors++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL last_ack_err: got %b expected 0", fetch_err); end
      vectors++; if (instruction !== 32'h0000_0020) begin errors++; $display("FAIL last_ack_ir: got %h expected %h", instruction, 32'h20); end
   endtask

   task automatic test_timeout();
      int b, v; logic [31:0] a;
      run_fetch(32'hFFFF_FFFF, 0, 1'b1, 20, b, v, a);
      vectors++; if (b !== 16) begin errors++; $display("FAIL timeout_busy: got %0d expected 16", b); end
      vectors++; if (v !== 0) begin errors++; $display("FAIL timeout_vld: got %0d expected 0", v); end
      vectors++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", fetch_err); end
      vectors++; if (instruction !== 32'h0000_0020) begin errors++; $display("FAIL timeout_ir: got %h expected %h", instruction, 32'h20); end
      run_fetch(32'h0000_0040, 1, 1'b1, 4, b, v, a);
      vectors++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", fetch_err); end
   endtask

   task automatic test_pcwr_in_req_and_rst();
      @(negedge clk);
      fetch_go = 1'b1;
      @(negedge clk);
      fetch_go = 1'b0; pc_wr = 1'b1; npc_sel = 2'b11; jr_addr = 32'h0000_5000;
      @(negedge clk);
      pc_wr = 1'b0;
      vectors++; if (pc !== 32'h0000_3104) begin errors++; $display("FAIL req_pcwr_pc: got %h expected %h", pc, 32'h3104); end
      vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL req_pcwr_req: got %b expected 1", imem_req); end
      #2 rst = 1'b1;
      #1;
      vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      vectors++; if (pc !== 32'h0000_3000) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, 32'h3000); end
      vectors++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
      @(negedge clk);
      rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      imem_ack = 1'b0;
      vectors++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL late_ack_vld: got %b expected 0", ir_valid); end
      vectors++; if (instruction !== 32'h0) begin errors++; $display("FAIL late_ack_ir: got %h expected %h", instruction, 32'h0); end
   endtask

   task automatic test_align();
      int b, v; logic [31:0] a;
      write_pc(2'b11, 1'b0, 32'h0000_3002);
      vectors++; if (pc !== 32'h0000_3002) begin errors++; $display("FAIL align_jr_pc: got %h expected %h", pc, 32'h3002); end
      run_fetch(32'h0000_0001, 2, 1'b1, 5, b, v, a);
`ifdef IFU_ALIGN_CHK_EN
      vectors++; if (b !== 0) begin errors++; $display("FAIL align_busy: got %0d expected 0", b); end
      vectors++; if (fetch_err !== 1'b1) begin errors++; $display("FAIL align_err: got %b expected 1", fetch_err); end
      vectors++; if (v !== 0) begin errors++; $display("FAIL align_vld: got %0d expected 0", v); end
`else
      vectors++; if (b !== 2) begin errors++; $display("FAIL align_busy: got %0d expected 2", b); end
      vectors++; if (a !== 32'h0000_3002) begin errors++; $display("FAIL align_addr: got %h expected %h", a, 32'h3002); end
      vectors++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL align_err: got %b expected 0", fetch_err); end
      vectors++; if (v !== 1) begin errors++; $display("FAIL align_vld: got %0d expected 1", v); end
`endif
   endtask

   initial begin
      rst = 1'b1; fetch_go = 1'b0; pc_wr = 1'b0; ir_wr = 1'b0; zero = 1'b0;
      npc_sel = 2'b00; jr_addr = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      test_reset();
      test_fetch();
      test_beq();
      test_jump();
      test_ir_wr_off();
      test_ack_outside();
      test_go_with_pcwr();
      test_ack_last_cycle();
      test_timeout();
      test_pcwr_in_req_and_rst();
      test_align();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
